// File: rtl/pipeline_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared types and constants for the five-stage pipeline stall/flush sequencer.
//   ctrl_state_t : sequencer FSM states
//   STG_*        : bit index of each pipeline-register boundary in stall/flush
//                  ([0]=PC/IF_ID, [1]=ID_EX, [2]=EX_MEM, [3]=MEM_WB)
//   CTRL_*       : raw hold/bubble encodings per hazard class. Where a hold and
//                  a bubble overlap on one boundary, the bubble wins when the
//                  outputs are resolved (see resolve_stall).
// -----------------------------------------------------------------------------
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    BUSY     = 2'd2,
    FLUSH    = 2'd3
  } ctrl_state_t;

  localparam int STG_IF = 0;
  localparam int STG_ID = 1;
  localparam int STG_EX = 2;
  localparam int STG_WB = 3;

  localparam logic [3:0] CTRL_NONE          = 4'b0000;
  localparam logic [3:0] CTRL_BR_FLUSH      = 4'(1 << STG_IF);
  localparam logic [3:0] CTRL_LU_FLUSH      = 4'(1 << STG_ID);
  localparam logic [3:0] CTRL_LU_STALL      = 4'((1 << STG_IF) | (1 << STG_ID));
  localparam logic [3:0] CTRL_BUSY_FLUSH    = 4'(1 << STG_EX);
  localparam logic [3:0] CTRL_BUSY_STALL    = CTRL_LU_STALL | CTRL_BUSY_FLUSH;
  localparam logic [3:0] CTRL_MEM_STALL     = CTRL_BUSY_STALL | 4'(1 << STG_WB);
  localparam logic [3:0] CTRL_EXC_FLUSH     = CTRL_MEM_STALL;
  localparam logic [3:0] CTRL_POSTEXC_FLUSH = CTRL_LU_STALL;

  // A boundary that is bubbled this cycle must not also be held.
  function automatic logic [3:0] resolve_stall(input logic [3:0] stall_raw,
                                               input logic [3:0] flush_raw);
    return stall_raw & ~flush_raw;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Purely combinational load-use compare between the ID sources and the EX
// destination. Writes to x0 never create a hazard.
// Ports:
//   id_rs1_en/id_rs1_addr, id_rs2_en/id_rs2_addr : ID source operands
//   ex_rw_en/ex_rw_addr                          : EX destination
//   ex_is_load                                   : EX instruction is a load
//   load_use                                     : hazard present this cycle
// -----------------------------------------------------------------------------
module hazard_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  id_rs1_en,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic                  id_rs2_en,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  ex_rw_en,
  input  logic [REG_ADDR_W-1:0] ex_rw_addr,
  input  logic                  ex_is_load,
  output logic                  load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_rs1_en & (id_rs1_addr == ex_rw_addr);
  assign rs2_hit  = id_rs2_en & (id_rs2_addr == ex_rw_addr);
  assign load_use = ex_is_load & ex_rw_en & (ex_rw_addr != '0) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
// Central stall/flush sequencer for the IF/ID/EX/MEM/WB core. Resolves, in
// fixed priority, exceptions > mem_busy > ex_busy > load-use > taken branch,
// and drives hold (stall) and bubble (flush) bits to the four pipeline
// register boundaries. Multi-cycle conditions are tracked by a small FSM with
// a busy watchdog.
//
// Optional build macro: PIPELINE_CTRL_PERF_EN adds the 32-bit wrapping
// counters stall_cycles and flush_events.
//
// Ports:
//   clk, rst (asynchronous, active-low)
//   id_rs1_en/addr, id_rs2_en/addr : ID source operands
//   ex_rw_en/addr, ex_is_load      : EX destination / load flag
//   ex_busy, mem_busy              : multi-cycle EX op / data memory wait
//   id_branch_taken                : taken branch/jump resolved in ID
//   except_valid                   : exception/ertn raised in MEM
//   stall[3:0], flush[3:0]         : hold/bubble per boundary
//   timeout_err                    : sticky busy-watchdog flag
//   stall_cycles, flush_events     : perf counters (macro builds only)
// -----------------------------------------------------------------------------
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W       = 5,
  parameter int LOAD_USE_PENALTY = 1,
  parameter int BUSY_TIMEOUT     = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_rs1_en,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic                  id_rs2_en,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  ex_rw_en,
  input  logic [REG_ADDR_W-1:0] ex_rw_addr,
  input  logic                  ex_is_load,
  input  logic                  ex_busy,
  input  logic                  mem_busy,
  input  logic                  id_branch_taken,
  input  logic                  except_valid,
  output logic [3:0]            stall,
  output logic [3:0]            flush,
  output logic                  timeout_err
`ifdef PIPELINE_CTRL_PERF_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_events
`endif
);

  localparam int BCNT_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [BCNT_W-1:0] BCNT_MAX = BCNT_W'(BUSY_TIMEOUT);
  localparam logic [BCNT_W-1:0] BCNT_ONE = BCNT_W'(1);
  localparam logic [1:0]        LU_LOAD  = 2'(LOAD_USE_PENALTY - 1);

  ctrl_state_t       state, state_nx;
  logic [1:0]        lu_cnt, lu_cnt_nx;
  logic [BCNT_W-1:0] busy_cnt, busy_cnt_nx;
  logic              terr_set;
  logic              load_use;
  logic              any_busy;
  logic              wd_fire;
  logic [3:0]        stall_raw;
  logic [3:0]        flush_raw;

  function automatic logic [BCNT_W-1:0] sat_inc(input logic [BCNT_W-1:0] c);
    return (c == BCNT_MAX) ? c : c + BCNT_ONE;
  endfunction

  hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard (
    .id_rs1_en   (id_rs1_en),
    .id_rs1_addr (id_rs1_addr),
    .id_rs2_en   (id_rs2_en),
    .id_rs2_addr (id_rs2_addr),
    .ex_rw_en    (ex_rw_en),
    .ex_rw_addr  (ex_rw_addr),
    .ex_is_load  (ex_is_load),
    .load_use    (load_use)
  );

  assign any_busy = ex_busy | mem_busy;
  // Watchdog fires on the cycle after BUSY_TIMEOUT consecutive busy cycles if
  // the unit is still busy; it then behaves exactly like an exception.
  assign wd_fire  = (state == BUSY) && any_busy && (busy_cnt == BCNT_MAX);

  always_comb begin
    state_nx    = state;
    lu_cnt_nx   = lu_cnt;
    busy_cnt_nx = busy_cnt;
    terr_set    = 1'b0;
    stall_raw   = CTRL_NONE;
    flush_raw   = CTRL_NONE;

    if (except_valid || wd_fire) begin
      flush_raw   = CTRL_EXC_FLUSH;
      state_nx    = FLUSH;
      lu_cnt_nx   = 2'd0;
      busy_cnt_nx = '0;
      terr_set    = wd_fire;
    end else begin
      case (state)
        // Fixed one-cycle slot after an exception: busy, load-use and branch
        // are all re-evaluated from RUN on the following cycle.
        FLUSH: begin
          flush_raw = CTRL_POSTEXC_FLUSH;
          state_nx  = RUN;
        end

        BUSY: begin
          if (mem_busy) begin
            stall_raw   = CTRL_MEM_STALL;
            busy_cnt_nx = sat_inc(busy_cnt);
          end else if (ex_busy) begin
            stall_raw   = CTRL_BUSY_STALL;
            flush_raw   = CTRL_BUSY_FLUSH;
            busy_cnt_nx = sat_inc(busy_cnt);
          end else begin
            // Release cycle: no hold at all, so only a branch can act here.
            state_nx    = RUN;
            busy_cnt_nx = '0;
            if (id_branch_taken) begin
              flush_raw = CTRL_BR_FLUSH;
            end
          end
        end

        LU_STALL: begin
          if (mem_busy || ex_busy) begin
            // Busy preempts the remaining load-use penalty.
            stall_raw   = mem_busy ? CTRL_MEM_STALL : CTRL_BUSY_STALL;
            flush_raw   = mem_busy ? CTRL_NONE : CTRL_BUSY_FLUSH;
            state_nx    = BUSY;
            busy_cnt_nx = BCNT_ONE;
            lu_cnt_nx   = 2'd0;
          end else begin
            stall_raw = CTRL_LU_STALL;
            flush_raw = CTRL_LU_FLUSH;
            lu_cnt_nx = lu_cnt - 2'd1;
            if (lu_cnt == 2'd1) begin
              state_nx = RUN;
            end
          end
        end

        default: begin
          if (mem_busy || ex_busy) begin
            stall_raw   = mem_busy ? CTRL_MEM_STALL : CTRL_BUSY_STALL;
            flush_raw   = mem_busy ? CTRL_NONE : CTRL_BUSY_FLUSH;
            state_nx    = BUSY;
            busy_cnt_nx = BCNT_ONE;
          end else if (load_use) begin
            stall_raw = CTRL_LU_STALL;
            flush_raw = CTRL_LU_FLUSH;
            if (LOAD_USE_PENALTY > 1) begin
              state_nx  = LU_STALL;
              lu_cnt_nx = LU_LOAD;
            end
          end else if (id_branch_taken) begin
            flush_raw = CTRL_BR_FLUSH;
          end
        end
      endcase
    end
  end

  // Reset forces a full flush combinationally, without waiting for a clock.
  always_comb begin
    if (!rst) begin
      stall = CTRL_NONE;
      flush = CTRL_EXC_FLUSH;
    end else begin
      stall = resolve_stall(stall_raw, flush_raw);
      flush = flush_raw;
    end
  end

  // ---- state / counter registers ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      lu_cnt      <= 2'd0;
      busy_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state    <= state_nx;
      lu_cnt   <= lu_cnt_nx;
      busy_cnt <= busy_cnt_nx;
      if (terr_set) begin
        timeout_err <= 1'b1;
      end
    end
  end

`ifdef PIPELINE_CTRL_PERF_EN
  logic flush0_q;

  // ---- performance counters ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
      flush0_q     <= 1'b1;
    end else begin
      flush0_q <= flush[STG_IF];
      if (|stall) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (flush[STG_IF] && !flush0_q) begin
        flush_events <= flush_events + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl
// Two instances share one stimulus stream: A (penalty 1, timeout 64) and
// B (penalty 3, timeout 8). A stimulus process drives inputs, steps a
// behavioural model per instance and queues the expected outputs; a monitor
// process pops and compares each cycle.
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;

  localparam int RW    = 5;
  localparam int PEN_A = 1;
  localparam int TMO_A = 64;
  localparam int PEN_B = 3;
  localparam int TMO_B = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          id_rs1_en, id_rs2_en, ex_rw_en, ex_is_load;
  logic [RW-1:0] id_rs1_addr, id_rs2_addr, ex_rw_addr;
  logic          ex_busy, mem_busy, id_branch_taken, except_valid;
  logic [3:0]    stall_a, flush_a, stall_b, flush_b;
  logic          terr_a, terr_b;
`ifdef PIPELINE_CTRL_PERF_EN
  logic [31:0]   sc_a, fe_a, sc_b, fe_b;
`endif

  pipeline_ctrl #(.REG_ADDR_W(RW), .LOAD_USE_PENALTY(PEN_A), .BUSY_TIMEOUT(TMO_A)) u_dut_a (
    .clk(clk), .rst(rst),
    .id_rs1_en(id_rs1_en), .id_rs1_addr(id_rs1_addr),
    .id_rs2_en(id_rs2_en), .id_rs2_addr(id_rs2_addr),
    .ex_rw_en(ex_rw_en), .ex_rw_addr(ex_rw_addr), .ex_is_load(ex_is_load),
    .ex_busy(ex_busy), .mem_busy(mem_busy),
    .id_branch_taken(id_branch_taken), .except_valid(except_valid),
    .stall(stall_a), .flush(flush_a), .timeout_err(terr_a)
`ifdef PIPELINE_CTRL_PERF_EN
    , .stall_cycles(sc_a), .flush_events(fe_a)
`endif
  );

  pipeline_ctrl #(.REG_ADDR_W(RW), .LOAD_USE_PENALTY(PEN_B), .BUSY_TIMEOUT(TMO_B)) u_dut_b (
    .clk(clk), .rst(rst),
    .id_rs1_en(id_rs1_en), .id_rs1_addr(id_rs1_addr),
    .id_rs2_en(id_rs2_en), .id_rs2_addr(id_rs2_addr),
    .ex_rw_en(ex_rw_en), .ex_rw_addr(ex_rw_addr), .ex_is_load(ex_is_load),
    .ex_busy(ex_busy), .mem_busy(mem_busy),
    .id_branch_taken(id_branch_taken), .except_valid(except_valid),
    .stall(stall_b), .flush(flush_b), .timeout_err(terr_b)
`ifdef PIPELINE_CTRL_PERF_EN
    , .stall_cycles(sc_b), .flush_events(fe_b)
`endif
  );

  typedef struct {
    bit       rs1_en;
    bit [4:0] rs1;
    bit       rs2_en;
    bit [4:0] rs2;
    bit       rw_en;
    bit [4:0] rw;
    bit       is_load;
    bit       exb;
    bit       memb;
    bit       br;
    bit       exc;
  } in_t;

  // Model state: remaining forced load-use cycles, length of the current busy
  // episode (0 = not in one), pending post-exception cycle, sticky error.
  typedef struct {
    int lu_left;
    int busy_len;
    bit flush_next;
    bit sticky;
  } mdl_t;

  typedef struct {
    bit [3:0] stall;
    bit [3:0] flush;
    bit       terr;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks   = 0;
  int   failures = 0;
  in_t  st;
  mdl_t ma, mb;

  function automatic void model_step(inout mdl_t m, input int pen, input int tmo,
                                     input in_t s, output exp_t e);
    bit       lu, busy, wd;
    bit [3:0] sv, fv;
    lu   = s.is_load && s.rw_en && (s.rw != 0) &&
           ((s.rs1_en && s.rs1 == s.rw) || (s.rs2_en && s.rs2 == s.rw));
    busy = s.exb || s.memb;
    wd   = (m.busy_len >= tmo) && busy;
    e.terr = m.sticky;
    sv = 4'b0000;
    fv = 4'b0000;
    if (s.exc || wd) begin
      fv = 4'b1111;
      m.flush_next = 1'b1;
      m.lu_left = 0;
      m.busy_len = 0;
      if (wd) m.sticky = 1'b1;
    end else if (m.flush_next) begin
      fv = 4'b0011;
      m.flush_next = 1'b0;
    end else if (busy) begin
      if (s.memb) sv = 4'b1111;
      else begin
        sv = 4'b0111;
        fv = 4'b0100;
      end
      m.busy_len = (m.busy_len + 1 > tmo) ? tmo : m.busy_len + 1;
      m.lu_left = 0;
    end else if (m.busy_len > 0) begin
      if (s.br) fv = 4'b0001;
      m.busy_len = 0;
    end else if (m.lu_left > 0) begin
      sv = 4'b0011;
      fv = 4'b0010;
      m.lu_left--;
    end else if (lu) begin
      sv = 4'b0011;
      fv = 4'b0010;
      m.lu_left = pen - 1;
    end else if (s.br) begin
      fv = 4'b0001;
    end
    e.stall = sv & ~fv;
    e.flush = fv;
  endfunction

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic clear_stim();
    st = '{default: 0};
  endtask

  task automatic apply_stim();
    id_rs1_en       = st.rs1_en;
    id_rs1_addr     = st.rs1;
    id_rs2_en       = st.rs2_en;
    id_rs2_addr     = st.rs2;
    ex_rw_en        = st.rw_en;
    ex_rw_addr      = st.rw;
    ex_is_load      = st.is_load;
    ex_busy         = st.exb;
    mem_busy        = st.memb;
    id_branch_taken = st.br;
    except_valid    = st.exc;
  endtask

  task automatic reset_models();
    ma = '{lu_left: 0, busy_len: 0, flush_next: 1'b0, sticky: 1'b0};
    mb = '{lu_left: 0, busy_len: 0, flush_next: 1'b0, sticky: 1'b0};
  endtask

  task automatic cyc();
    exp_t ea, eb;
    @(posedge clk);
    #1;
    apply_stim();
    model_step(ma, PEN_A, TMO_A, st, ea);
    model_step(mb, PEN_B, TMO_B, st, eb);
    q_a.push_back(ea);
    q_b.push_back(eb);
  endtask

  task automatic check_reset_vals(input string tag);
    check4({tag, "_a_stall"}, stall_a, 4'b0000);
    check4({tag, "_a_flush"}, flush_a, 4'b1111);
    check4({tag, "_a_terr"}, {3'b0, terr_a}, 4'b0000);
    check4({tag, "_b_stall"}, stall_b, 4'b0000);
    check4({tag, "_b_flush"}, flush_b, 4'b1111);
    check4({tag, "_b_terr"}, {3'b0, terr_b}, 4'b0000);
  endtask

  // Monitor: outputs are presented every stimulated cycle; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        check4("a_stall", stall_a, e.stall);
        check4("a_flush", flush_a, e.flush);
        check4("a_terr", {3'b0, terr_a}, {3'b0, e.terr});
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        check4("b_stall", stall_b, e.stall);
        check4("b_flush", flush_b, e.flush);
        check4("b_terr", {3'b0, terr_b}, {3'b0, e.terr});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    clear_stim();
    apply_stim();
    reset_models();
    rst = 1'b0;
    #2;
    check_reset_vals("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Load-use on rs1
    clear_stim();
    st.is_load = 1; st.rw_en = 1; st.rw = 5; st.rs1_en = 1; st.rs1 = 5;
    cyc();
    clear_stim();
    repeat (4) cyc();

    // Load-use on rs2 and to x0 (no hazard)
    st.is_load = 1; st.rw_en = 1; st.rw = 9; st.rs2_en = 1; st.rs2 = 9;
    cyc();
    clear_stim();
    repeat (3) cyc();
    st.is_load = 1; st.rw_en = 1; st.rw = 0; st.rs1_en = 1; st.rs1 = 0;
    repeat (2) cyc();
    clear_stim();

    // ex_busy 4 cycles, release, then ex_busy + mem_busy
    st.exb = 1;
    repeat (4) cyc();
    st.exb = 0;
    repeat (2) cyc();
    st.exb = 1; st.memb = 1;
    repeat (2) cyc();
    clear_stim();
    cyc();

    // Exception during BUSY
    st.memb = 1;
    repeat (3) cyc();
    st.exc = 1;
    cyc();
    clear_stim();
    repeat (3) cyc();

    // Load-use together with a taken branch, then branch alone
    st.is_load = 1; st.rw_en = 1; st.rw = 3; st.rs1_en = 1; st.rs1 = 3; st.br = 1;
    cyc();
    clear_stim();
    st.br = 1;
    repeat (3) cyc();
    clear_stim();
    cyc();

    // Watchdog: mem_busy held past both timeouts
    st.memb = 1;
    repeat (70) cyc();

    // Asynchronous reset mid-BUSY, away from any clock edge
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_reset_vals("async_rst");
    @(posedge clk);
    #1;
    clear_stim();
    apply_stim();
    reset_models();
    rst = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      st.rs1_en  = ($urandom_range(0, 3) != 0);
      st.rs1     = 5'($urandom_range(0, 3));
      st.rs2_en  = ($urandom_range(0, 1) != 0);
      st.rs2     = 5'($urandom_range(0, 3));
      st.rw_en   = ($urandom_range(0, 3) != 0);
      st.rw      = 5'($urandom_range(0, 3));
      st.is_load = ($urandom_range(0, 1) != 0);
      st.exb     = ($urandom_range(0, 7) == 0) || (st.exb && $urandom_range(0, 3) != 0);
      st.memb    = ($urandom_range(0, 9) == 0) || (st.memb && $urandom_range(0, 4) != 0);
      st.br      = ($urandom_range(0, 3) == 0);
      st.exc     = ($urandom_range(0, 40) == 0);
      cyc();
    end
    clear_stim();
    repeat (3) cyc();

    // Bounded drain of the scoreboard
    repeat (3) @(posedge clk);
    check4("drain_a", 4'(q_a.size()), 4'd0);
    check4("drain_b", 4'(q_b.size()), 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
